// File: rtl/dco_acq_pkg.sv
`timescale 1ns/1fs
// ---------------------------------------------------------------------------
// dco_acq_pkg
// Shared types and defaults for the DCO coarse frequency-acquisition block.
//   acq_state_t   : sequencer states
//   *_DEF         : default parameter values used by dco_freq_acq_ctrl
//   dctrl_offset  : mid-scale offset between the unsigned search code and
//                   the signed DCO control word
// ---------------------------------------------------------------------------
package dco_acq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      ALIGN  = 3'd2,
      MEAS   = 3'd3,
      DECIDE = 3'd4,
      DONE   = 3'd5
   } acq_state_t;

   localparam int unsigned DCTRL_W_DEF      = 32'd16;
   localparam int unsigned CNT_W_DEF        = 32'd16;
   localparam int unsigned REF_WIN_DEF      = 32'd64;
   localparam int unsigned SETTLE_EDGES_DEF = 32'd4;
   localparam int unsigned TOL_DEF          = 32'd2;

   // 2^(w-1): subtracting this from the unsigned code gives the signed dctrl,
   // so code 0 is the slowest setting and all-ones the fastest.
   function automatic logic [31:0] dctrl_offset(input int unsigned w);
      return 32'd1 << (w - 32'd1);
   endfunction

endpackage

// File: rtl/ref_edge_sync.sv
`timescale 1ns/1fs
// ---------------------------------------------------------------------------
// ref_edge_sync
// Brings the asynchronous reference clock into the pclk domain through a
// two-flop synchronizer and emits a one-pclk pulse per refclk rising edge.
// The pulse follows the refclk rise by 2-3 pclk cycles.
// Ports:
//   pclk     in  : sampling clock
//   resetn   in  : asynchronous active-low reset
//   refclk   in  : reference clock, treated as asynchronous data
//   ref_edge out : one-cycle pulse per synchronized rising edge
// ---------------------------------------------------------------------------
module ref_edge_sync (
   input  logic pclk,
   input  logic resetn,
   input  logic refclk,
   output logic ref_edge
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;

   // Next-state of the synchronizer chain and the edge-detect history flop.
   always_comb begin
      sync1_d = refclk;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // Synchronizer and edge-detect registers.
   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   // Kept combinational on purpose: a registered pulse would push the
   // edge latency past three pclk cycles.
   assign ref_edge = sync2_q & ~prev_q;

endmodule

// File: rtl/dco_freq_acq_ctrl.sv
`timescale 1ns/1fs
// ---------------------------------------------------------------------------
// dco_freq_acq_ctrl
// Coarse frequency acquisition for the DCO. A successive-approximation search
// over the control code measures the DCO frequency by counting pclk cycles
// across REF_WIN refclk periods, keeping each trial bit only if the count does
// not exceed divn*REF_WIN. One extra verify measurement on the final code
// reports locked (within TOL counts) or fail.
// Ports:
//   pclk       in  : DCO output clock, clocks all state
//   resetn     in  : asynchronous active-low reset
//   refclk     in  : reference clock, asynchronous to pclk
//   start      in  : one-cycle acquisition request (ignored while busy)
//   abort      in  : synchronous abort to IDLE, code and meas_count held
//   divn       in  : target ratio f(pclk)/f(refclk), latched at start
//   dctrl      out : signed DCO control word (code - 2^(DCTRL_W-1))
//   busy       out : high outside IDLE and DONE
//   locked     out : verify measurement within tolerance
//   fail       out : verify measurement outside tolerance
//   meas_count out : last latched window count
// Parameter limits: REF_WIN a power of two >= 2, SETTLE_EDGES >= 1.
// ---------------------------------------------------------------------------
module dco_freq_acq_ctrl
   import dco_acq_pkg::*;
#(
   parameter int unsigned DCTRL_W      = DCTRL_W_DEF,
   parameter int unsigned CNT_W        = CNT_W_DEF,
   parameter int unsigned REF_WIN      = REF_WIN_DEF,
   parameter int unsigned SETTLE_EDGES = SETTLE_EDGES_DEF,
   parameter int unsigned TOL          = TOL_DEF
) (
   input  logic                                  pclk,
   input  logic                                  resetn,
   input  logic                                  refclk,
   input  logic                                  start,
   input  logic                                  abort,
   input  logic [CNT_W-1:0]                      divn,
   output logic signed [DCTRL_W-1:0]             dctrl,
   output logic                                  busy,
   output logic                                  locked,
   output logic                                  fail,
   output logic [CNT_W+$clog2(REF_WIN)-1:0]      meas_count
);

   localparam int unsigned WIN_LG = $clog2(REF_WIN);
   localparam int unsigned MEAS_W = CNT_W + WIN_LG;
   localparam int unsigned IDX_W  = $clog2(DCTRL_W);
   localparam int unsigned EDGE_W = $clog2(REF_WIN + SETTLE_EDGES + 1);

   localparam logic [DCTRL_W-1:0] CODE_MID    = DCTRL_W'(dctrl_offset(DCTRL_W));
   localparam logic [IDX_W-1:0]   IDX_TOP     = IDX_W'(DCTRL_W - 1);
   localparam logic [EDGE_W-1:0]  LAST_SETTLE = EDGE_W'(SETTLE_EDGES - 1);
   localparam logic [EDGE_W-1:0]  LAST_WIN    = EDGE_W'(REF_WIN - 1);
   localparam logic [MEAS_W-1:0]  TOL_V       = MEAS_W'(TOL);
   localparam logic [MEAS_W-1:0]  CNT_MAX     = {MEAS_W{1'b1}};

   acq_state_t          state_q, state_d;
   logic [DCTRL_W-1:0]  code_q, code_d;
   logic [DCTRL_W-1:0]  dctrl_q, dctrl_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic [MEAS_W-1:0]   cnt_q, cnt_d;
   logic [MEAS_W-1:0]   meas_q, meas_d;
   logic [MEAS_W-1:0]   target_q, target_d;
   logic                verify_q, verify_d;
   logic                locked_q, locked_d;
   logic                fail_q, fail_d;
   logic                busy_q, busy_d;

   logic                ref_edge;
   logic [MEAS_W-1:0]   cnt_inc;
   logic [MEAS_W-1:0]   meas_err;
   logic [DCTRL_W-1:0]  code_v;

   ref_edge_sync u_ref_edge_sync (
      .pclk     (pclk),
      .resetn   (resetn),
      .refclk   (refclk),
      .ref_edge (ref_edge)
   );

   // Sequencer next-state, SAR code update and measurement bookkeeping.
   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      idx_d      = idx_q;
      edge_cnt_d = edge_cnt_q;
      cnt_d      = cnt_q;
      meas_d     = meas_q;
      target_d   = target_q;
      verify_d   = verify_q;
      locked_d   = locked_q;
      fail_d     = fail_q;
      code_v     = code_q;

      // The count that includes the current cycle, saturating at all ones.
      cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + MEAS_W'(1);
      meas_err = (meas_q >= target_q) ? (meas_q - target_q) : (target_q - meas_q);

      if (abort) begin
         // Abort beats everything, including a simultaneous start.
         state_d  = IDLE;
         locked_d = 1'b0;
         fail_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  locked_d   = 1'b0;
                  fail_d     = 1'b0;
                  target_d   = MEAS_W'(divn) << WIN_LG;
                  idx_d      = IDX_TOP;
                  code_d     = CODE_MID;   // only the top trial bit set
                  verify_d   = 1'b0;
                  edge_cnt_d = '0;
                  state_d    = SETTLE;
               end else begin
                  state_d = state_q;
               end
            end

            SETTLE: begin
               if (ref_edge) begin
                  if (edge_cnt_q == LAST_SETTLE) begin
                     edge_cnt_d = '0;
                     state_d    = ALIGN;
                  end else begin
                     edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                  end
               end else begin
                  edge_cnt_d = edge_cnt_q;
               end
            end

            ALIGN: begin
               // Start the window exactly on a reference edge.
               if (ref_edge) begin
                  cnt_d      = '0;
                  edge_cnt_d = '0;
                  state_d    = MEAS;
               end else begin
                  state_d = state_q;
               end
            end

            MEAS: begin
               cnt_d = cnt_inc;
               if (ref_edge) begin
                  if (edge_cnt_q == LAST_WIN) begin
                     meas_d  = cnt_inc;
                     state_d = DECIDE;
                  end else begin
                     edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                  end
               end else begin
                  edge_cnt_d = edge_cnt_q;
               end
            end

            DECIDE: begin
               if (!verify_q) begin
                  // Too fast: drop the bit under trial.
                  if (meas_q > target_q) begin
                     code_v[idx_q] = 1'b0;
                  end else begin
                     code_v[idx_q] = code_q[idx_q];
                  end
                  if (idx_q != '0) begin
                     idx_d                  = idx_q - IDX_W'(1);
                     code_v[idx_q - IDX_W'(1)] = 1'b1;
                  end else begin
                     // All bits resolved; one more window on the final code.
                     verify_d = 1'b1;
                  end
                  code_d     = code_v;
                  edge_cnt_d = '0;
                  state_d    = SETTLE;
               end else begin
                  if (meas_err <= TOL_V) begin
                     locked_d = 1'b1;
                  end else begin
                     fail_d = 1'b1;
                  end
                  state_d = DONE;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d  = (state_d != IDLE) && (state_d != DONE);
      dctrl_d = code_d - DCTRL_W'(dctrl_offset(DCTRL_W));
   end

   // State and output registers.
   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         code_q     <= CODE_MID;
         dctrl_q    <= '0;
         idx_q      <= IDX_TOP;
         edge_cnt_q <= '0;
         cnt_q      <= '0;
         meas_q     <= '0;
         target_q   <= '0;
         verify_q   <= 1'b0;
         locked_q   <= 1'b0;
         fail_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         dctrl_q    <= dctrl_d;
         idx_q      <= idx_d;
         edge_cnt_q <= edge_cnt_d;
         cnt_q      <= cnt_d;
         meas_q     <= meas_d;
         target_q   <= target_d;
         verify_q   <= verify_d;
         locked_q   <= locked_d;
         fail_q     <= fail_d;
         busy_q     <= busy_d;
      end
   end

   assign dctrl      = dctrl_q;
   assign busy       = busy_q;
   assign locked     = locked_q;
   assign fail       = fail_q;
   assign meas_count = meas_q;

endmodule

// File: tb/tb_dco_freq_acq_ctrl.sv
`timescale 1ns/1fs
// ---------------------------------------------------------------------------
// tb_dco_freq_acq_ctrl
// Behavioural DCO (3.99 GHz + 5 kHz/code, clamped 3-5 GHz) closing the loop
// around the acquisition controller with a 100 MHz refclk. The window is
// shortened to 16 refclk periods and settling to 2 edges so the whole run
// stays short; one count is then worth 1250 codes instead of 312.5.
// ---------------------------------------------------------------------------
module tb_dco_freq_acq_ctrl;

   localparam int TB_WIN = 16;
   localparam int TB_SET = 2;
   localparam int TRIAL_NS = (TB_SET + 1 + TB_WIN) * 10;
   localparam int RUN_NS = 17 * TRIAL_NS;

   typedef struct {
      int          id;
      logic [15:0] divn;
      int          exp_locked;
      int          exp_fail;
      int          dctrl_lo;
      int          dctrl_hi;
   } vec_t;

   logic               pclk;
   logic               resetn;
   logic               refclk;
   logic               start;
   logic               abort;
   logic [15:0]        divn;
   logic signed [15:0] dctrl;
   logic               busy;
   logic               locked;
   logic               fail;
   logic [19:0]        meas_count;

   int checks   = 0;
   int failures = 0;
   vec_t exp_q[$];
   vec_t vecs[3];

   dco_freq_acq_ctrl #(
      .DCTRL_W      (16),
      .CNT_W        (16),
      .REF_WIN      (TB_WIN),
      .SETTLE_EDGES (TB_SET),
      .TOL          (2)
   ) dut (
      .pclk       (pclk),
      .resetn     (resetn),
      .refclk     (refclk),
      .start      (start),
      .abort      (abort),
      .divn       (divn),
      .dctrl      (dctrl),
      .busy       (busy),
      .locked     (locked),
      .fail       (fail),
      .meas_count (meas_count)
   );

   function automatic real dco_freq(input logic signed [15:0] d);
      int  di;
      real f;
      di = d;
      f  = 3.99e9 + 5.0e3 * $itor(di);
      if (f < 3.0e9) f = 3.0e9;
      if (f > 5.0e9) f = 5.0e9;
      return f;
   endfunction

   // DCO: pclk half period follows the current control word.
   initial begin
      real half_ns;
      pclk = 1'b0;
      forever begin
         half_ns = 0.5e9 / dco_freq(dctrl);
         #(half_ns) pclk = ~pclk;
      end
   end

   // 100 MHz reference.
   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   task automatic check_int(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Drive one acquisition, optionally with a stray start mid-search, and
   // score the result against the expectation queued at start.
   task automatic run_vec(input vec_t v, input bit collide);
      vec_t             e;
      realtime          t0;
      int               cyc;
      int               lo;
      int               tgt;
      real              model;
      logic signed [15:0] d0;
      @(negedge pclk);
      divn  = v.divn;
      start = 1'b1;
      exp_q.push_back(v);
      t0 = $realtime;
      @(negedge pclk);
      start = 1'b0;
      if (collide) begin
         cyc = 0;
         while (dctrl == 16'sd0 && cyc < 8000) begin
            @(negedge pclk);
            cyc++;
         end
         check_int("collide_first_decide", int'(dctrl != 16'sd0), 1, 1);
         repeat (80) @(negedge pclk);
         d0    = dctrl;
         start = 1'b1;
         @(negedge pclk);
         start = 1'b0;
         check_int("collide_busy", int'(busy), 1, 1);
         check_int("collide_dctrl_held", int'(dctrl), int'(d0), int'(d0));
      end
      cyc = 0;
      while (busy && cyc < 40000) begin
         @(negedge pclk);
         cyc++;
      end
      check_int($sformatf("v%0d_done", v.id), int'(busy), 0, 0);
      e = exp_q.pop_front();
      check_int($sformatf("v%0d_busy_ns", e.id), int'($realtime - t0), RUN_NS - 15, RUN_NS + 15);
      check_int($sformatf("v%0d_locked", e.id), int'(locked), e.exp_locked, e.exp_locked);
      check_int($sformatf("v%0d_fail", e.id), int'(fail), e.exp_fail, e.exp_fail);
      check_int($sformatf("v%0d_dctrl", e.id), int'(dctrl), e.dctrl_lo, e.dctrl_hi);
      model = dco_freq(dctrl) * $itor(TB_WIN) * 10.0e-9;
      lo    = $rtoi(model);
      check_int($sformatf("v%0d_meas_model", e.id), int'(meas_count), lo - 1, lo + 2);
      if (e.exp_locked == 1) begin
         tgt = int'(e.divn) * TB_WIN;
         check_int($sformatf("v%0d_meas_target", e.id), int'(meas_count), tgt - 2, tgt + 2);
      end
   endtask

   initial begin
      int                 cyc;
      int                 changes;
      logic signed [15:0] prev;
      logic signed [15:0] held;

      // divn 40 -> 4.00 GHz (code 2000), divn 60 -> 6 GHz beyond the top of
      // the range (all bits kept), divn 30 -> 3 GHz below it (all cleared).
      vecs[0] = '{0, 16'd40, 1, 0, 2000 - 1300, 2000 + 1300};
      vecs[1] = '{1, 16'd60, 0, 1, 32767, 32767};
      vecs[2] = '{2, 16'd30, 0, 1, -32768, -32768};

      start  = 1'b0;
      abort  = 1'b0;
      divn   = 16'd40;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      #20;
      check_int("rst_dctrl", int'(dctrl), 0, 0);
      check_int("rst_busy", int'(busy), 0, 0);
      check_int("rst_locked", int'(locked), 0, 0);
      check_int("rst_fail", int'(fail), 0, 0);
      check_int("rst_meas", int'(meas_count), 0, 0);
      @(negedge pclk);
      resetn = 1'b1;
      repeat (10) @(negedge pclk);

      for (int k = 0; k < 3; k++) begin
         run_vec(vecs[k], 1'b0);
      end

      // Abort during the measurement window of trial 5.
      @(negedge pclk);
      divn  = 16'd40;
      start = 1'b1;
      @(negedge pclk);
      start = 1'b0;
      check_int("abort_run_busy", int'(busy), 1, 1);
      prev    = dctrl;
      changes = 0;
      cyc     = 0;
      while (changes < 4 && cyc < 20000) begin
         @(negedge pclk);
         cyc++;
         if (dctrl != prev) begin
            changes++;
            prev = dctrl;
         end
      end
      check_int("abort_reach_trial5", changes, 4, 4);
      #80;
      @(negedge pclk);
      held  = dctrl;
      abort = 1'b1;
      @(negedge pclk);
      abort = 1'b0;
      check_int("abort_busy", int'(busy), 0, 0);
      check_int("abort_dctrl_held", int'(dctrl), int'(held), int'(held));
      check_int("abort_flags", int'({locked, fail}), 0, 0);
      repeat (100) @(negedge pclk);
      check_int("abort_idle_busy", int'(busy), 0, 0);
      check_int("abort_idle_dctrl", int'(dctrl), int'(held), int'(held));

      // start together with abort stays in IDLE.
      start = 1'b1;
      abort = 1'b1;
      @(negedge pclk);
      start = 1'b0;
      abort = 1'b0;
      check_int("start_abort_busy", int'(busy), 0, 0);
      check_int("start_abort_dctrl", int'(dctrl), int'(held), int'(held));
      repeat (20) @(negedge pclk);
      check_int("start_abort_idle", int'(busy), 0, 0);

      // Restart after abort, with a start pulse ignored mid-search.
      run_vec(vecs[0], 1'b1);

      // Asynchronous reset during SETTLE.
      @(negedge pclk);
      divn  = 16'd40;
      start = 1'b1;
      @(negedge pclk);
      start = 1'b0;
      cyc = 0;
      while (dctrl == 16'sd0 && cyc < 8000) begin
         @(negedge pclk);
         cyc++;
      end
      check_int("areset_searching", int'(busy), 1, 1);
      #5.3 resetn = 1'b0;
      #0.1;
      check_int("areset_dctrl_now", int'(dctrl), 0, 0);
      check_int("areset_busy_now", int'(busy), 0, 0);
      #2.9 resetn = 1'b1;
      #200;
      check_int("areset_after_dctrl", int'(dctrl), 0, 0);
      check_int("areset_after_busy", int'(busy), 0, 0);
      check_int("areset_after_flags", int'({locked, fail}), 0, 0);
      check_int("areset_after_meas", int'(meas_count), 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dco_freq_acq_ctrl.md
# dco_freq_acq_ctrl

Coarse frequency-acquisition sequencer for the DCO. On `start` it runs a successive-approximation search over the DCO control word, measuring DCO frequency by counting `pclk` cycles across a window of `refclk` periods. It then runs one verify measurement and reports `locked` or `fail`. It sits between loop bring-up logic and the DCO's `dctrl` input, and hands a near-target code to the phase-sampling loop.

## Interface
- `DCTRL_W`, 16: width of signed `dctrl`.
- `CNT_W`, 16: width of `divn` and the measurement counter.
- `REF_WIN`, 64: `refclk` periods per measurement window (power of two, ≥2).
- `SETTLE_EDGES`, 4: `refclk` rising edges ignored after each `dctrl` change.
- `TOL`, 2: allowed |count − target| in the verify measurement.

Ports:
- `pclk`  in  1: DCO output clock; all state is clocked here.
- `resetn`  in  1: reset, asynchronous, active-low.
- `refclk`  in  1: reference clock, asynchronous to `pclk`, treated as data.
- `start`  in  1: one-cycle request to begin acquisition.
- `abort`  in  1: synchronous abort; return to IDLE, hold `dctrl`.
- `divn`  in  CNT_W: target ratio f(pclk)/f(refclk), unsigned, ≥1.
- `dctrl`  out  DCTRL_W: signed DCO control word.
- `busy`  out  1: high outside IDLE/DONE.
- `locked`  out  1: verify passed.
- `fail`  out  1: verify failed.
- `meas_count`  out  CNT_W+log2(REF_WIN): last latched window count.

## Operation
- Internal unsigned `code`; `dctrl = code − 2^(DCTRL_W−1)`, so a higher code means a higher frequency.
- `target = divn * REF_WIN`, latched at `start`.
- refclk path: 2-flop synchronizer plus edge-detect flop; `ref_edge` is a one-`pclk` pulse per rising edge.
- States:
  - IDLE: on `start`, clear `locked`/`fail`; set `code = 0` and bit index `i = DCTRL_W−1`; set `code[i] = 1`; go to SETTLE.
  - SETTLE: count `SETTLE_EDGES` `ref_edge` pulses, then go to ALIGN.
  - ALIGN: on the next `ref_edge`, clear counter and edge count, then go to MEAS.
  - MEAS: counter +1 every `pclk` cycle, saturating at all ones. On the `REF_WIN`-th `ref_edge`, latch the counter (that cycle included) into `meas_count`, then go to DECIDE.
  - DECIDE (1 cycle), search phase:
    - If `meas_count > target`, clear `code[i]`.
    - If `i > 0`: `i−1`, set `code[i−1]`, go to SETTLE.
    - If `i == 0`: go to SETTLE for the verify pass.
  - DECIDE, verify phase: if |meas_count − target| ≤ TOL, set `locked`; else set `fail`. Go to DONE.
  - DONE: hold `code` and flags. `start` restarts the search (IDLE behaviour).
- `start` is ignored while `busy`.
- `abort` in any state goes to IDLE next cycle. `code` and `meas_count` are held, `locked`/`fail` are cleared, and abort wins over a simultaneous `start`.
- `divn` changes are ignored until the next `start`.

## Timing
- Reset values: `code = 2^(DCTRL_W−1)` (so `dctrl = 0`), `busy = 0`, `locked = 0`, `fail = 0`, `meas_count = 0`, state IDLE, synchronizer flops = 0.
- `busy` rises the cycle after `start`.
- `ref_edge` follows a `refclk` rise by 2–3 `pclk` cycles.
- Window count is ideally `divn*REF_WIN`, with ±1 quantization.
- Per trial: (SETTLE_EDGES + 1 + REF_WIN) refclk periods plus ≤4 `pclk` cycles.
- Total: DCTRL_W + 1 trials.
- `dctrl` changes only on the DECIDE→SETTLE cycle and at IDLE start.
- `locked`/`fail` assert the cycle after the final DECIDE and are mutually exclusive.
- `resetn` low mid-search: all state returns to reset values immediately (async); a new `start` is required.

## Structure
- Package `dco_acq_pkg`:
  - state enum `acq_state_t` (IDLE, SETTLE, ALIGN, MEAS, DECIDE, DONE);
  - default widths;
  - `dctrl` offset function.
- Sub-module `ref_edge_sync`: 2-flop sync plus rising-edge pulse, async active-low reset.
- FSM and SAR logic stay in the top module.

## Test plan
All scenarios use this behavioural DCO: F0 = 3.99 GHz, KDCO = 5 kHz/code, clamp 3–5 GHz. Default `refclk` = 100 MHz.
- **Reset:** `resetn` low → `dctrl = 0`, `busy = 0`, `locked = 0`, `fail = 0`.
- **Nominal lock:** `divn = 40`, `start` → `dctrl` within 2000 ± 320; `locked = 1`; `|meas_count − 2560| ≤ 2`; 17 trials.
- **Out of range:** `divn = 60` (6 GHz, above FMAX) → all bits kept, `dctrl = 32767`, `fail = 1`, `locked = 0`.
- **Abort:** pulse `abort` during MEAS of trial 5 → IDLE next cycle, `busy = 0`, `dctrl` holds. A later `start` completes to `locked`.
- **Collisions:**
  - `start` while `busy` → ignored, search unchanged.
  - `start` together with `abort` → IDLE.
- **Async reset mid-search:** `resetn` low for 3 ns during SETTLE → `dctrl = 0` immediately. After release, outputs stay at reset values until `start`.
